// File: rtl/down_counter_nbit_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | down_counter_pkg : state encoding and constants for down_counter_nbit |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
package down_counter_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      COUNT = 2'd1,
      DONE  = 2'd2
   } cnt_state_t;

   // All-ones reload value; users slice [WIDTH-1:0], so WIDTH must not exceed 32.
   localparam logic [31:0] RELOAD_RST_VAL = 32'hFFFF_FFFF;

endpackage : down_counter_pkg
`default_nettype wire

// File: rtl/down_counter_nbit_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | down_counter_nbit_if : control/status bundle of the down counter      |
// | Optional macro DOWN_CNT_GRAY_OUT_EN adds count_gray. Rev 1.0          |
// +----------------------------------------------------------------------+
interface down_counter_nbit_if #(
   parameter int WIDTH = 3
);
   logic             en;
   logic             load;
   logic [WIDTH-1:0] load_val;
   logic             auto_reload;
   logic [WIDTH-1:0] count;
   logic             busy;
   logic             tc;
`ifdef DOWN_CNT_GRAY_OUT_EN
   logic [WIDTH-1:0] count_gray;

   modport master (output en, load, load_val, auto_reload,
                   input  count, busy, tc, count_gray);
   modport slave  (input  en, load, load_val, auto_reload,
                   output count, busy, tc, count_gray);
`else
   modport master (output en, load, load_val, auto_reload,
                   input  count, busy, tc);
   modport slave  (input  en, load, load_val, auto_reload,
                   output count, busy, tc);
`endif
endinterface : down_counter_nbit_if
`default_nettype wire

// File: rtl/down_counter_nbit_bin2gray.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | bin2gray : combinational binary to reflected-Gray converter           |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module bin2gray #(
   parameter int WIDTH = 3
) (
   input  wire logic [WIDTH-1:0] bin_i,
   output      logic [WIDTH-1:0] gray_o
);
   assign gray_o = bin_i ^ (bin_i >> 1);
endmodule : bin2gray
`default_nettype wire

// File: rtl/down_counter_nbit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | down_counter_nbit : loadable N-bit down counter, one-shot/auto-reload |
// | Optional macro DOWN_CNT_GRAY_OUT_EN adds registered count_gray. Rev 1.0|
// +----------------------------------------------------------------------+
module down_counter_nbit
   import down_counter_pkg::*;
#(
   parameter int WIDTH = 3
) (
   input wire logic           clk,
   input wire logic           reset,
   down_counter_nbit_if.slave bus
);

   cnt_state_t       state_q, state_d;
   logic [WIDTH-1:0] count_q, count_d;
   logic [WIDTH-1:0] reload_q, reload_d;
   logic             tc_q, tc_d;
   logic             busy_q, busy_d;

   always_comb begin
      state_d  = state_q;
      count_d  = count_q;
      reload_d = reload_q;
      tc_d     = 1'b0;
      if (bus.load) begin
         reload_d = bus.load_val;
         count_d  = bus.load_val;
         state_d  = (bus.load_val != '0) ? COUNT : IDLE;
      end else begin
         case (state_q)
            IDLE: ;
            COUNT: begin
               if (bus.en) begin
                  if (count_q > WIDTH'(1)) begin
                     count_d = count_q - WIDTH'(1);
                  end else if (count_q == WIDTH'(1)) begin
                     count_d = '0;
                     tc_d    = 1'b1;
                  end else if (bus.auto_reload) begin
                     count_d = reload_q;
                  end else begin
                     state_d = DONE;
                  end
               end
            end
            DONE:    count_d = '0;
            default: state_d = IDLE;
         endcase
      end
      busy_d = (state_d == COUNT);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         count_q  <= '0;
         reload_q <= RELOAD_RST_VAL[WIDTH-1:0];
         tc_q     <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         count_q  <= count_d;
         reload_q <= reload_d;
         tc_q     <= tc_d;
         busy_q   <= busy_d;
      end
   end

   assign bus.count = count_q;
   assign bus.busy  = busy_q;
   assign bus.tc    = tc_q;

`ifdef DOWN_CNT_GRAY_OUT_EN
   logic [WIDTH-1:0] gray_d, gray_q;

   // Converting the next count keeps the Gray output aligned with count.
   bin2gray #(.WIDTH(WIDTH)) u_bin2gray (
      .bin_i  (count_d),
      .gray_o (gray_d)
   );

   always_ff @(posedge clk) begin
      if (reset) gray_q <= '0;
      else       gray_q <= gray_d;
   end

   assign bus.count_gray = gray_q;
`endif

endmodule : down_counter_nbit
`default_nettype wire
